// File: rtl/spi_master_byte_pkg.sv
// Shared types and constants for the byte-wide SPI master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_master_byte_pkg;

  // Transfer sequencing: idle, clocking bits, one-cycle wrap-up.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // {CPOL, CPHA}: mode 0 idles SCLK low and samples on the rising edge.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic       SCLK_IDLE = SPI_MODE0[1];

  localparam int DATA_W_DEF = 8;

  // One counter value per SCLK half-period across a whole transfer.
  function automatic int tick_cnt_w(input int data_w);
    return $clog2(2 * data_w);
  endfunction

endpackage

// File: rtl/spi_master_byte_shift.sv
// Datapath for the SPI master: tx/rx shift registers, mosi register, half-period tick counter.
// Latency: load presents the first bit on mosi one clk later; each strobe acts in one clk.
// Backpressure: none; it only moves when the FSM strobes it.
module spi_master_byte_shift
  import spi_master_byte_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              tick_en,
  input  logic              sample,
  input  logic              shift_tx,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_byte,
  output logic              tick_odd,
  output logic              tick_last
);

  localparam int             TW        = tick_cnt_w(DATA_W);
  localparam logic [TW-1:0]  TICK_LAST = TW'(2 * DATA_W - 1);

  logic [TW-1:0]     tick_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] tx_nxt;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_nxt;
  logic              first_bit;
  logic              next_bit;

  assign tick_odd  = tick_cnt[0];
  assign tick_last = (tick_cnt == TICK_LAST);
  assign rx_byte   = rx_sh;

  // Shift direction and bit selection follow the configured bit order.
  always_comb begin
    tx_nxt    = '0;
    rx_nxt    = '0;
    first_bit = 1'b0;
    next_bit  = 1'b0;
    if (MSB_FIRST != 0) begin
      tx_nxt    = {tx_sh[DATA_W-2:0], 1'b0};
      rx_nxt    = {rx_sh[DATA_W-2:0], miso};
      first_bit = data_in[DATA_W-1];
      next_bit  = tx_nxt[DATA_W-1];
    end else begin
      tx_nxt    = {1'b0, tx_sh[DATA_W-1:1]};
      rx_nxt    = {miso, rx_sh[DATA_W-1:1]};
      first_bit = data_in[0];
      next_bit  = tx_nxt[0];
    end
  end

  // Half-period counter; restarts on load and parks at the last tick instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (load) begin
      tick_cnt <= '0;
    end else if (tick_en && !tick_last) begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Transmit shifter and mosi: first bit at load, next bit on each non-final falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sh <= '0;
      mosi  <= 1'b0;
    end else if (load) begin
      tx_sh <= data_in;
      mosi  <= first_bit;
    end else if (shift_tx) begin
      tx_sh <= tx_nxt;
      mosi  <= next_bit;
    end else if (clear) begin
      mosi  <= 1'b0;
    end
  end

  // Receive shifter: miso captured on every rising SCLK edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sh <= '0;
    end else if (load) begin
      rx_sh <= '0;
    end else if (sample) begin
      rx_sh <= rx_nxt;
    end
  end

endmodule

// File: rtl/spi_master_byte.sv
// Byte-wide SPI mode-0 master: drives SCLK/MOSI from ena_2clk ticks, samples MISO, reports busy.
// Latency: busy 1 clk after accepted start; 2*DATA_W ticks + 1 clk to rx_valid.
// Backpressure: start is ignored while busy; the controller waits for busy low between bytes.
module spi_master_byte
  import spi_master_byte_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_2clk,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid
);

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              tick_en;
  logic              sample;
  logic              shift_tx;
  logic              fall;
  logic              finish;
  logic              tick_odd;
  logic              tick_last;
  logic [DATA_W-1:0] rx_byte;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: start only matters in IDLE; the final falling tick ends the shift phase.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (ena_2clk && tick_odd && tick_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath strobes; a tick arriving with start in IDLE is dropped because tick_en needs SHIFT.
  always_comb begin
    load     = 1'b0;
    tick_en  = 1'b0;
    sample   = 1'b0;
    fall     = 1'b0;
    shift_tx = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE:  load = start;
      ST_SHIFT: begin
        tick_en  = ena_2clk;
        sample   = ena_2clk && !tick_odd;
        fall     = ena_2clk && tick_odd;
        shift_tx = ena_2clk && tick_odd && !tick_last;
      end
      ST_DONE:  finish = 1'b1;
      default:  ;
    endcase
  end

  spi_master_byte_shift #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .tick_en   (tick_en),
    .sample    (sample),
    .shift_tx  (shift_tx),
    .clear     (finish),
    .data_in   (data_in),
    .miso      (miso),
    .mosi      (mosi),
    .rx_byte   (rx_byte),
    .tick_odd  (tick_odd),
    .tick_last (tick_last)
  );

  // SCLK rises on even ticks, falls on odd ticks, and is forced idle on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk <= SCLK_IDLE;
    end else if (sample) begin
      sclk <= ~SCLK_IDLE;
    end else if (fall || finish) begin
      sclk <= SCLK_IDLE;
    end
  end

  // busy is purely registered so start never reaches it combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else if (load) begin
      busy <= 1'b1;
    end else if (finish) begin
      busy <= 1'b0;
    end
  end

  // Received byte is published once per transfer with a one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= finish;
      if (finish) begin
        data_out <= rx_byte;
      end
    end
  end

endmodule
